// File: rtl/petersen_edge_sequencer.sv
// Petersen graph edge sequencer.
// Steps a single SPI line-drawing engine through the 15 edges of a Petersen
// graph. The vertex and edge tables are held in an internal ROM. For each
// edge the sequencer loads the endpoint coordinates, pulses the engine start,
// and waits for the engine's done. It then inserts a programmable gap before
// the next edge. A stalled engine raises a sticky timeout error.
//
// Parameters
//   GAP      idle cycles between a line's done and the next edge (0 allowed)
//   TIMEOUT  max cycles spent waiting for done; 0 disables the timeout
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous active-low reset
//   i_start        request to draw the full graph (honoured only when idle)
//   i_line_done    done from the line engine, pulse or level (rising edge used)
//   o_line_start   one-cycle start to the line engine
//   o_x1..o_y2     endpoint coordinates of the current edge
//   o_edge_idx     current edge index, 0..14
//   o_busy         high whenever not idle
//   o_done         one-cycle pulse after the 15th edge completes
//   o_err          sticky timeout flag, cleared by the next accepted start
module petersen_edge_sequencer #(
  parameter int unsigned GAP     = 4,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_line_done,
  output logic       o_line_start,
  output logic [8:0] o_x1,
  output logic [8:0] o_y1,
  output logic [8:0] o_x2,
  output logic [8:0] o_y2,
  output logic [3:0] o_edge_idx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);
  localparam logic [23:0] TO_LAST  = TIMEOUT - 24'd1;
  localparam logic [3:0]  LAST_IDX = 4'd14;

  // ADV is the shared advance step. It is reached from WAIT when GAP is 0,
  // otherwise from GAP. Taking one cycle there gives the done-to-start
  // spacing of GAP+3 cycles.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_ADV   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        done_q;
  logic [3:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic [7:0]  gap_q, gap_d;
  logic [23:0] to_q, to_d;
  logic [8:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;

  logic        done_rise;
  logic [7:0]  ev;
  logic [17:0] p1, p2;

  // Vertex ROM: returns {x, y}.
  function automatic logic [17:0] vtx(input logic [3:0] v);
    case (v)
      4'd0:    vtx = {9'd120, 9'd60};
      4'd1:    vtx = {9'd215, 9'd129};
      4'd2:    vtx = {9'd179, 9'd241};
      4'd3:    vtx = {9'd61,  9'd241};
      4'd4:    vtx = {9'd25,  9'd129};
      4'd5:    vtx = {9'd120, 9'd110};
      4'd6:    vtx = {9'd168, 9'd145};
      4'd7:    vtx = {9'd149, 9'd200};
      4'd8:    vtx = {9'd91,  9'd200};
      4'd9:    vtx = {9'd72,  9'd145};
      default: vtx = '0;
    endcase
  endfunction

  // Edge ROM: returns {first vertex, second vertex}.
  // Edges 0-4 form the outer pentagon, 5-9 are the spokes, and 10-14 form
  // the inner pentagram.
  function automatic logic [7:0] edge_vs(input logic [3:0] k);
    case (k)
      4'd0:    edge_vs = {4'd0, 4'd1};
      4'd1:    edge_vs = {4'd1, 4'd2};
      4'd2:    edge_vs = {4'd2, 4'd3};
      4'd3:    edge_vs = {4'd3, 4'd4};
      4'd4:    edge_vs = {4'd4, 4'd0};
      4'd5:    edge_vs = {4'd0, 4'd5};
      4'd6:    edge_vs = {4'd1, 4'd6};
      4'd7:    edge_vs = {4'd2, 4'd7};
      4'd8:    edge_vs = {4'd3, 4'd8};
      4'd9:    edge_vs = {4'd4, 4'd9};
      4'd10:   edge_vs = {4'd5, 4'd7};
      4'd11:   edge_vs = {4'd6, 4'd8};
      4'd12:   edge_vs = {4'd7, 4'd9};
      4'd13:   edge_vs = {4'd8, 4'd5};
      4'd14:   edge_vs = {4'd9, 4'd6};
      default: edge_vs = '0;
    endcase
  endfunction

  assign done_rise = i_line_done & ~done_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      gap_q   <= '0;
      to_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= i_line_done;
      idx_q   <= idx_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
    end
  end

  always_comb begin
    ev           = edge_vs(idx_q);
    p1           = vtx(ev[7:4]);
    p2           = vtx(ev[3:0]);
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = err_q;
    gap_d        = gap_q;
    to_d         = to_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    x2_d         = x2_q;
    y2_d         = y2_q;
    o_line_start = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        x1_d    = p1[17:9];
        y1_d    = p1[8:0];
        x2_d    = p2[17:9];
        y2_d    = p2[8:0];
        state_d = S_START;
      end
      S_START: begin
        o_line_start = 1'b1;
        to_d         = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        to_d  = to_q + 24'd1;
        gap_d = '0;
        if (done_rise) begin
          state_d = (GAP != 0) ? S_GAP : S_ADV;
        end else if ((TIMEOUT != 24'd0) && (to_q == TO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GAP_LAST) begin
          state_d = S_ADV;
        end
      end
      S_ADV: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        o_busy  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_x1       = x1_q;
  assign o_y1       = y1_q;
  assign o_x2       = x2_q;
  assign o_y2       = y2_q;
  assign o_edge_idx = idx_q;
  assign o_err      = err_q;

endmodule

// File: doc/petersen_edge_sequencer.md
Name: petersen_edge_sequencer

Overview:
- Sequences the SPI line-drawing engine through the 15 edges of a Petersen graph held in an internal vertex/edge ROM.
- For each edge, presents endpoint coordinates, pulses the engine's start, and waits for its done.
- Inserts a programmable gap between edges, flags engine timeouts, and signals completion of the whole figure.
- Sits between the top-level trigger logic and the single line engine that owns MOSI/DC/CS.

Parameters:
- GAP, 4, idle cycles between a line's done and the next edge's load (0 allowed).
- TIMEOUT, 24'd10_000_000, max cycles in WAIT before error; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle request to draw the full graph; ignored unless IDLE.
- i_line_done  in  1  done from the line engine; pulse or level, rising edge is used.
- o_line_start  out  1  one-cycle start to the line engine.
- o_x1, o_y1, o_x2, o_y2  out  9 each  edge endpoint coordinates.
- o_edge_idx  out  4  index of the current edge, 0..14.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when all 15 edges are drawn.
- o_err  out  1  sticky timeout flag; cleared by the next accepted i_start or by reset.

Behaviour:
- Reset (asynchronous, i_rst low): state IDLE; all outputs 0; edge index 0; rising-edge history register cleared.
- Reset mid-operation: immediate return to IDLE; o_line_start deasserts at once.
- Vertex ROM (x,y):
  - v0 (120,60), v1 (215,129), v2 (179,241), v3 (61,241), v4 (25,129)
  - v5 (120,110), v6 (168,145), v7 (149,200), v8 (91,200), v9 (72,145)
- Edge k:
  - k=0..4: (k, (k+1) mod 5).
  - k=5..9: (k-5, k).
  - k=10..14: (j+5, ((j+2) mod 5)+5), where j=k-10.
  - Endpoint 1 is the first vertex, endpoint 2 the second.
- Rising edge: done_rise = i_line_done & ~done_q, with done_q registered every cycle.
- State IDLE: on i_start go to LOAD; edge index 0; o_err cleared.
- State LOAD (1 cycle): register coordinates for the current edge, then go to START.
- State START (1 cycle): o_line_start=1, then go to WAIT; reset the timeout counter.
- State WAIT:
  - On done_rise go to GAP if GAP>0; if GAP=0 go straight to the advance step.
  - done_rise in the START cycle itself is ignored.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1: set o_err and go to IDLE without o_done.
- State GAP: count GAP cycles, then advance.
- Advance step: if edge index = 14, go to DONE; otherwise increment the index and go to LOAD.
- State DONE (1 cycle): o_done=1, then go to IDLE.
- Coordinate stability: coordinates hold from LOAD until the next LOAD; they are not cleared in IDLE after completion.
- o_edge_idx: tracks the register and remains 14 after completion until the next start.
- Latency: i_start high at cycle 0 gives o_line_start high at cycle 2.
- Gap timing: done_rise at cycle t gives the next o_line_start at t+GAP+3.
- i_start outside IDLE: ignored, with no effect on the sequence.
- Unused encodings: any unused state decodes to IDLE.
- Counter widths: GAP counter is 8 bits; timeout counter is 24 bits.

Test Plan:
- Reset with i_rst=0, then release → all outputs 0, o_busy=0. Pulse i_start → o_line_start at +2 cycles with x1=120, y1=60, x2=215, y2=129, o_edge_idx=0.
- Engine model returns a 1-cycle done 50 cycles after each start, GAP=4 → 15 start pulses, in order. Edge 5 is (120,60)-(120,110); edge 10 is (120,110)-(149,200); edge 14 is (72,145)-(168,145). o_done pulses once after the 15th done; o_busy then falls.
- Engine holds done as a level (high until the next start) → each edge is still advanced exactly once. No double-advance occurs; total starts = 15.
- i_start pulsed repeatedly during WAIT of edge 3 → no restart. o_edge_idx continues 3→4, and the start count stays 15.
- TIMEOUT=100 with the engine never asserting done → o_err=1 at 100 cycles after the start; state returns to IDLE with o_done=0. A new i_start clears o_err and restarts at edge 0.
- Drive i_rst=0 mid-WAIT of edge 7, asynchronously between clock edges → outputs go to 0 immediately. After release, i_start begins again at edge 0.
